// File: rtl/vlsu_txn_dispatcher.sv
// vlsu_txn_dispatcher
//   Routes transaction-control flits from the ControlMachine to NrUnits
//   execution units through one registered FIFO per unit. Tracks queued
//   (occ) and in-flight (infl) transactions per unit, caps the total
//   outstanding work at MaxOutstanding and raises the CM update pulse on
//   every unit handshake.
//
// Build option:
//   VLSU_DISPATCH_ORDER_EN - when defined, a global order queue records the
//   destination unit of every accepted flit. Only the unit at its head may
//   present a flit, and only while every other unit has nothing in flight.
//   This serialises units so loads and stores cannot overtake each other.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               drop every queued (not yet popped) flit
//   in_valid_i/in_ready_o input handshake; in_unit_i selects the unit,
//                         in_data_i is the payload
//   out_valid_o/out_ready_i  per-unit output handshake
//   out_data_o            per-unit head payload, unit u at [u*DataWidth +: DataWidth]
//   cmpl_i                per-unit completion pulse (retires one in-flight txn)
//   update_o              any output handshake this cycle
//   outstanding_o         total queued + in-flight
//   idle_o                nothing queued or in flight
//   err_o                 sticky protocol error (bad unit, spurious completion)

module vlsu_txn_dispatcher #(
  parameter int unsigned NrUnits        = 2,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned FifoDepth      = 4,
  parameter int unsigned MaxOutstanding = 8,
  localparam int unsigned UnitW = (NrUnits > 1) ? $clog2(NrUnits) : 1,
  localparam int unsigned OutW  = $clog2(MaxOutstanding + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [UnitW-1:0]               in_unit_i,
  input  logic [DataWidth-1:0]           in_data_i,
  output logic [NrUnits-1:0]             out_valid_o,
  input  logic [NrUnits-1:0]             out_ready_i,
  output logic [NrUnits*DataWidth-1:0]   out_data_o,
  input  logic [NrUnits-1:0]             cmpl_i,
  output logic                           update_o,
  output logic [OutW-1:0]                outstanding_o,
  output logic                           idle_o,
  output logic                           err_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  logic [DataWidth-1:0] mem_q    [NrUnits][FifoDepth];
  logic [PtrW-1:0]      rd_ptr_q [NrUnits];
  logic [PtrW-1:0]      rd_ptr_d [NrUnits];
  logic [PtrW-1:0]      wr_ptr_q [NrUnits];
  logic [PtrW-1:0]      wr_ptr_d [NrUnits];
  logic [CntW-1:0]      occ_q    [NrUnits];
  logic [CntW-1:0]      occ_d    [NrUnits];
  logic [OutW-1:0]      infl_q   [NrUnits];
  logic [OutW-1:0]      infl_d   [NrUnits];
  logic                 err_q, err_d;

  logic [NrUnits-1:0]   full, empty, push, pop, cmpl_ok, ord_ok;
  logic                 unit_in_range, unit_full, accept;
  logic [OutW-1:0]      out_sum;

  // --------------------------------------------------------------------
  // Status and input handshake
  // --------------------------------------------------------------------
  always_comb begin
    for (int u = 0; u < NrUnits; u++) begin
      full[u]  = (occ_q[u] == CntW'(FifoDepth));
      empty[u] = (occ_q[u] == '0);
    end
  end

  // occ and infl never exceed the cap, so summing in OutW bits cannot wrap.
  always_comb begin
    out_sum = '0;
    for (int u = 0; u < NrUnits; u++) begin
      out_sum = out_sum + OutW'(occ_q[u]) + infl_q[u];
    end
  end

  assign outstanding_o = out_sum;
  assign idle_o        = (out_sum == '0);
  assign err_o         = err_q;

  assign unit_in_range = (32'(in_unit_i) < NrUnits);
  assign unit_full     = unit_in_range ? full[in_unit_i] : 1'b0;

  // An out-of-range unit is still "accepted" so the CM is not stalled; the
  // flit is dropped and flagged through err_o.
  assign in_ready_o = !rst_i && !flush_i &&
                      (out_sum < OutW'(MaxOutstanding)) && !unit_full;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    for (int u = 0; u < NrUnits; u++) begin
      push[u] = accept && unit_in_range && (in_unit_i == UnitW'(u));
    end
  end

  // --------------------------------------------------------------------
  // Optional global ordering
  // --------------------------------------------------------------------
`ifdef VLSU_DISPATCH_ORDER_EN
  localparam int unsigned OrdDepth = NrUnits * FifoDepth;
  localparam int unsigned OrdPtrW  = (OrdDepth > 1) ? $clog2(OrdDepth) : 1;
  localparam int unsigned OrdCntW  = $clog2(OrdDepth + 1);

  logic [UnitW-1:0]   oq_mem_q [OrdDepth];
  logic [OrdPtrW-1:0] oq_rd_q, oq_rd_d, oq_wr_q, oq_wr_d;
  logic [OrdCntW-1:0] oq_cnt_q, oq_cnt_d;
  logic [UnitW-1:0]   head_unit;
  logic               others_busy, oq_push, oq_pop;

  assign head_unit = oq_mem_q[oq_rd_q];
  assign oq_push   = |push;
  // Only the head unit can be valid, so at most one pop per cycle.
  assign oq_pop    = |pop;

  always_comb begin
    others_busy = 1'b0;
    for (int v = 0; v < NrUnits; v++) begin
      if ((UnitW'(v) != head_unit) && (infl_q[v] != '0)) begin
        others_busy = 1'b1;
      end
    end
    for (int u = 0; u < NrUnits; u++) begin
      ord_ok[u] = (oq_cnt_q != '0) && (head_unit == UnitW'(u)) && !others_busy;
    end
  end

  always_comb begin
    oq_rd_d  = oq_rd_q;
    oq_wr_d  = oq_wr_q;
    oq_cnt_d = oq_cnt_q + OrdCntW'(oq_push) - OrdCntW'(oq_pop);
    if (oq_push) begin
      oq_wr_d = (32'(oq_wr_q) == OrdDepth - 1) ? '0 : oq_wr_q + OrdPtrW'(1);
    end
    if (oq_pop) begin
      oq_rd_d = (32'(oq_rd_q) == OrdDepth - 1) ? '0 : oq_rd_q + OrdPtrW'(1);
    end
    if (flush_i) begin
      oq_rd_d  = '0;
      oq_wr_d  = '0;
      oq_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      oq_rd_q  <= '0;
      oq_wr_q  <= '0;
      oq_cnt_q <= '0;
    end else begin
      oq_rd_q  <= oq_rd_d;
      oq_wr_q  <= oq_wr_d;
      oq_cnt_q <= oq_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (oq_push) begin
      oq_mem_q[oq_wr_q] <= in_unit_i;
    end
  end
`else
  assign ord_ok = '1;
`endif

  // --------------------------------------------------------------------
  // Output side
  // --------------------------------------------------------------------
  // Flush suppresses presentation so nothing pops from a FIFO being cleared.
  assign out_valid_o = ~empty & ord_ok & {NrUnits{!rst_i && !flush_i}};
  assign pop         = out_valid_o & out_ready_i;
  assign update_o    = |pop;

  always_comb begin
    out_data_o = '0;
    for (int u = 0; u < NrUnits; u++) begin
      out_data_o[u*DataWidth +: DataWidth] = mem_q[u][rd_ptr_q[u]];
    end
  end

  // A completion is legal if something is in flight or is being popped in
  // the same cycle; otherwise it is ignored and flagged.
  always_comb begin
    for (int u = 0; u < NrUnits; u++) begin
      cmpl_ok[u] = cmpl_i[u] && ((infl_q[u] != '0) || pop[u]);
    end
  end

  // --------------------------------------------------------------------
  // Next-state
  // --------------------------------------------------------------------
  always_comb begin
    err_d = err_q;
    if (accept && !unit_in_range) begin
      err_d = 1'b1;
    end
    for (int u = 0; u < NrUnits; u++) begin
      rd_ptr_d[u] = pop[u]  ? rd_ptr_q[u] + PtrW'(1) : rd_ptr_q[u];
      wr_ptr_d[u] = push[u] ? wr_ptr_q[u] + PtrW'(1) : wr_ptr_q[u];
      occ_d[u]    = occ_q[u] + CntW'(push[u]) - CntW'(pop[u]);
      infl_d[u]   = infl_q[u] + OutW'(pop[u]) - OutW'(cmpl_ok[u]);
      if (cmpl_i[u] && !cmpl_ok[u]) begin
        err_d = 1'b1;
      end
      // In-flight work is already at the unit and survives a flush.
      if (flush_i) begin
        rd_ptr_d[u] = '0;
        wr_ptr_d[u] = '0;
        occ_d[u]    = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
      for (int u = 0; u < NrUnits; u++) begin
        rd_ptr_q[u] <= '0;
        wr_ptr_q[u] <= '0;
        occ_q[u]    <= '0;
        infl_q[u]   <= '0;
      end
    end else begin
      err_q <= err_d;
      for (int u = 0; u < NrUnits; u++) begin
        rd_ptr_q[u] <= rd_ptr_d[u];
        wr_ptr_q[u] <= wr_ptr_d[u];
        occ_q[u]    <= occ_d[u];
        infl_q[u]   <= infl_d[u];
      end
    end
  end

  // Payload storage needs no reset; validity is carried by occ.
  always_ff @(posedge clk_i) begin
    for (int u = 0; u < NrUnits; u++) begin
      if (push[u]) begin
        mem_q[u][wr_ptr_q[u]] <= in_data_i;
      end
    end
  end

endmodule

// File: tb/tb_vlsu_txn_dispatcher.sv
module tb_vlsu_txn_dispatcher;

  logic         clk_sys = 1'b0;
  logic         rst, flush, in_valid, in_ready, in_unit;
  logic [63:0]  in_data;
  logic [1:0]   out_valid, out_ready, cmpl;
  logic [127:0] out_data;
  logic         update, idle, err;
  logic [3:0]   outstanding;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  always #5 clk_sys = ~clk_sys;

  vlsu_txn_dispatcher dut (
    .clk_i        (clk_sys),
    .rst_i        (rst),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_unit_i    (in_unit),
    .in_data_i    (in_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .cmpl_i       (cmpl),
    .update_o     (update),
    .outstanding_o(outstanding),
    .idle_o       (idle),
    .err_o        (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic u, input logic [63:0] d);
    in_valid = 1'b1;
    in_unit  = u;
    in_data  = d;
    #1;
    chk("send_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
  endtask

  // Scoreboard: accepted flits are queued per unit; every output handshake
  // must deliver the oldest queued flit of that unit.
  always @(negedge clk_sys) begin
    if (rst || flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (in_valid && in_ready) begin
        if (in_unit == 1'b0) q0.push_back(in_data);
        else                 q1.push_back(in_data);
      end
      if (out_valid[0] && out_ready[0]) begin
        if (q0.size() == 0) chk("sb0_unexpected_pop", 64'd1, 64'd0);
        else                chk("sb0_data", out_data[63:0], q0.pop_front());
      end
      if (out_valid[1] && out_ready[1]) begin
        if (q1.size() == 0) chk("sb1_unexpected_pop", 64'd1, 64'd0);
        else                chk("sb1_data", out_data[127:64], q1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_unit = 1'b0; in_data = '0;
    out_ready = '0; cmpl = '0;
    cyc();
    cyc();
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_update", 64'(update), 64'd0);

    // 1: single accept, no fall-through
    in_valid = 1'b1; in_unit = 1'b0; in_data = 64'hA5;
    #1;
    chk("t1_ready", 64'(in_ready), 64'd1);
    chk("t1_no_fallthru", 64'(out_valid), 64'd0);
    cyc();
    in_valid = 1'b0;
    #1;
    chk("t1_valid", 64'(out_valid), 64'b01);
    chk("t1_data", out_data[63:0], 64'hA5);
    chk("t1_outstanding", 64'(outstanding), 64'd1);
    chk("t1_idle", 64'(idle), 64'd0);
    out_ready = 2'b01;
    #1;
    chk("t1_update", 64'(update), 64'd1);
    cyc();
    out_ready = 2'b00;
    #1;
    chk("t1_infl", 64'(outstanding), 64'd1);
    chk("t1_popped", 64'(out_valid), 64'd0);
    cmpl = 2'b01;
    cyc();
    cmpl = 2'b00;
    #1;
    chk("t1_retired", 64'(outstanding), 64'd0);
    chk("t1_idle_again", 64'(idle), 64'd1);

    // 2: unit1 full blocks only unit1
    for (int i = 0; i < 4; i++) send(1'b1, 64'h100 + 64'(i));
    in_unit = 1'b1;
    #1;
    chk("t2_full_u1", 64'(in_ready), 64'd0);
    in_unit = 1'b0;
    #1;
    chk("t2_u0_ready", 64'(in_ready), 64'd1);
    send(1'b0, 64'h200);
    #1;
    chk("t2_outstanding", 64'(outstanding), 64'd5);
    out_ready = 2'b10;
    in_unit   = 1'b1;
    #1;
    chk("t2_full_same_cycle", 64'(in_ready), 64'd0);
    cyc();
    out_ready = 2'b00;
    #1;
    chk("t2_free_next", 64'(in_ready), 64'd1);
    out_ready = 2'b11;
    for (int i = 0; i < 10; i++) begin
      cyc();
      #1;
      if (out_valid == 2'b00) break;
    end
    out_ready = 2'b00;
    chk("t2_drained", 64'(out_valid), 64'd0);
    chk("t2_all_infl", 64'(outstanding), 64'd5);
    cmpl = 2'b11;
    cyc();
    cmpl = 2'b10;
    repeat (3) cyc();
    cmpl = 2'b00;
    #1;
    chk("t2_clean", 64'(outstanding), 64'd0);
    chk("t2_err", 64'(err), 64'd0);

    // 3: outstanding cap
    for (int i = 0; i < 8; i++) send(i[0], 64'h300 + 64'(i));
    #1;
    chk("t3_outstanding", 64'(outstanding), 64'd8);
    out_ready = 2'b11;
    repeat (4) cyc();
    out_ready = 2'b00;
    in_unit   = 1'b0;
    #1;
    chk("t3_drained", 64'(out_valid), 64'd0);
    chk("t3_cap_count", 64'(outstanding), 64'd8);
    chk("t3_cap_ready", 64'(in_ready), 64'd0);
    cmpl = 2'b01;
    cyc();
    cmpl = 2'b00;
    #1;
    chk("t3_after_cmpl", 64'(outstanding), 64'd7);
    chk("t3_ready_again", 64'(in_ready), 64'd1);
    cmpl = 2'b11;
    repeat (3) cyc();
    cmpl = 2'b10;
    cyc();
    cmpl = 2'b00;
    #1;
    chk("t3_clean", 64'(outstanding), 64'd0);

    // 4: accept + pop + cmpl on unit0 in one cycle
    send(1'b0, 64'h401);
    out_ready = 2'b01;
    cyc();
    out_ready = 2'b00;
    send(1'b0, 64'h402);
    #1;
    chk("t4_setup", 64'(outstanding), 64'd2);
    in_valid = 1'b1; in_unit = 1'b0; in_data = 64'h403;
    out_ready = 2'b01; cmpl = 2'b01;
    #1;
    chk("t4_update", 64'(update), 64'd1);
    chk("t4_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0; out_ready = 2'b00; cmpl = 2'b00;
    #1;
    chk("t4_outstanding", 64'(outstanding), 64'd2);
    chk("t4_valid", 64'(out_valid), 64'b01);
    chk("t4_err", 64'(err), 64'd0);
    out_ready = 2'b01;
    cyc();
    out_ready = 2'b00;
    cmpl = 2'b01;
    repeat (2) cyc();
    cmpl = 2'b00;
    #1;
    chk("t4_clean", 64'(outstanding), 64'd0);

    // 5: flush keeps in-flight, spurious completion flags error
    send(1'b0, 64'h501);
    out_ready = 2'b01;
    cyc();
    out_ready = 2'b00;
    send(1'b0, 64'h502);
    send(1'b0, 64'h503);
    send(1'b1, 64'h504);
    #1;
    chk("t5_setup", 64'(outstanding), 64'd4);
    flush = 1'b1; out_ready = 2'b11;
    #1;
    chk("t5_flush_valid", 64'(out_valid), 64'd0);
    chk("t5_flush_update", 64'(update), 64'd0);
    chk("t5_flush_ready", 64'(in_ready), 64'd0);
    cyc();
    flush = 1'b0; out_ready = 2'b00;
    #1;
    chk("t5_outstanding", 64'(outstanding), 64'd1);
    chk("t5_empty", 64'(out_valid), 64'd0);
    cmpl = 2'b10;
    cyc();
    cmpl = 2'b00;
    #1;
    chk("t5_err", 64'(err), 64'd1);
    chk("t5_ignored", 64'(outstanding), 64'd1);
    cmpl = 2'b01;
    cyc();
    cmpl = 2'b00;
    #1;
    chk("t5_clean", 64'(outstanding), 64'd0);
    chk("t5_err_sticky", 64'(err), 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("t5_err_cleared", 64'(err), 64'd0);

    // 6: cross-unit ordering
    send(1'b0, 64'h601);
    send(1'b1, 64'h602);
    send(1'b0, 64'h603);
    #1;
`ifdef VLSU_DISPATCH_ORDER_EN
    chk("t6_head_u0", 64'(out_valid), 64'b01);
    out_ready = 2'b11;
    cyc();
    #1;
    chk("t6_u1_waits", 64'(out_valid), 64'b00);
    cmpl = 2'b01;
    cyc();
    cmpl = 2'b00;
    #1;
    chk("t6_u1_go", 64'(out_valid), 64'b10);
    cyc();
    #1;
    chk("t6_u0_waits", 64'(out_valid), 64'b00);
    cmpl = 2'b10;
    cyc();
    cmpl = 2'b00;
    #1;
    chk("t6_u0_go", 64'(out_valid), 64'b01);
    cyc();
    out_ready = 2'b00;
    #1;
    chk("t6_outstanding", 64'(outstanding), 64'd1);
    cmpl = 2'b01;
    cyc();
    cmpl = 2'b00;
`else
    chk("t6_indep", 64'(out_valid), 64'b11);
    out_ready = 2'b11;
    cyc();
    #1;
    chk("t6_u0_second", 64'(out_valid), 64'b01);
    cyc();
    out_ready = 2'b00;
    #1;
    chk("t6_empty", 64'(out_valid), 64'b00);
    chk("t6_outstanding", 64'(outstanding), 64'd3);
    cmpl = 2'b11;
    cyc();
    cmpl = 2'b01;
    cyc();
    cmpl = 2'b00;
`endif
    #1;
    chk("t6_clean", 64'(outstanding), 64'd0);

    // 7: reset mid-operation discards state; later completion is an error
    send(1'b1, 64'h701);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("t7_outstanding", 64'(outstanding), 64'd0);
    chk("t7_idle", 64'(idle), 64'd1);
    chk("t7_valid", 64'(out_valid), 64'd0);
    cmpl = 2'b10;
    cyc();
    cmpl = 2'b00;
    #1;
    chk("t7_err", 64'(err), 64'd1);

    chk("sb_leftover", 64'(q0.size() + q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
